capsense_scanner: RTL and testbench

Time-multiplexed capacitive-touch front end for the hm2 capsense option, with NumSense pads per instance. The block drives the pads: it actively discharges each one, then releases it so the external pull-up can charge it. It times the charge against the pad input and reports per-channel charge counts and debounced touch flags. It sits between the GPIO pad mux, which consumes the oe/out pair, and the hm2 register interface, which consumes the counts and flags.

---
 rtl/capsense_scanner.sv | 171 +++++++++++++++++
 tb/tb_capsense_scanner.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/capsense_scanner.sv
// Round-robin capacitive pad scanner: discharges each pad, releases it, times the
// pull-up charge against the synchronised pad input and reports counts and touch flags.
module capsense_scanner #(
    parameter int NumSense        = 4,
    parameter int CountWidth      = 16,
    parameter int DischargeCycles = 64,
    parameter int ChanWidth       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [CountWidth-1:0] threshold,
    input  logic [CountWidth-1:0] hysteresis,
    input  logic [NumSense-1:0]   sense_in,
    output logic [NumSense-1:0]   sense_oe,
    output logic [NumSense-1:0]   sense_out,
    output logic [NumSense-1:0]   touched,
    output logic [CountWidth-1:0] count_out,
    output logic [ChanWidth-1:0]  count_chan,
    output logic                  count_valid,
    output logic                  timeout
);

    localparam int DisWidth = (DischargeCycles > 1) ? $clog2(DischargeCycles) : 1;
    localparam logic [CountWidth-1:0] MaxCount = '1;
    localparam logic [DisWidth-1:0]   DisLast  = DisWidth'(DischargeCycles - 1);
    localparam logic [ChanWidth-1:0]  ChanLast = ChanWidth'(NumSense - 1);

    typedef enum logic [1:0] {
        IDLE,
        DISCHARGE,
        CHARGE,
        REPORT
    } state_t;

    state_t                state_q, state_d;
    logic [ChanWidth-1:0]  chan_q, chan_d;
    logic [DisWidth-1:0]   dis_q, dis_d;
    logic [CountWidth-1:0] cnt_q, cnt_d;
    logic [NumSense-1:0]   sync_meta_q, sync_meta_d;
    logic [NumSense-1:0]   sync_q, sync_d;
    logic [NumSense-1:0]   sense_oe_q, sense_oe_d;
    logic [NumSense-1:0]   touched_q, touched_d;
    logic [CountWidth-1:0] count_out_q, count_out_d;
    logic [ChanWidth-1:0]  count_chan_q, count_chan_d;
    logic                  count_valid_q, count_valid_d;
    logic                  timeout_q, timeout_d;

    logic [CountWidth:0]   release_ext;
    logic [CountWidth-1:0] release_level;
    logic                  pad_high;

    // Touch-off level is threshold minus hysteresis, floored at zero rather than wrapping.
    assign release_ext   = {1'b0, threshold} - {1'b0, hysteresis};
    assign release_level = release_ext[CountWidth] ? '0 : release_ext[CountWidth-1:0];
    assign pad_high      = sync_q[chan_q];

    always_comb begin
        state_d       = state_q;
        chan_d        = chan_q;
        dis_d         = dis_q;
        cnt_d         = cnt_q;
        sync_meta_d   = sense_in;
        sync_d        = sync_meta_q;
        touched_d     = touched_q;
        count_out_d   = count_out_q;
        count_chan_d  = count_chan_q;
        count_valid_d = 1'b0;
        timeout_d     = timeout_q;

        case (state_q)
            IDLE: begin
                chan_d = '0;
                dis_d  = '0;
                if (enable) begin
                    state_d = DISCHARGE;
                end
            end

            DISCHARGE: begin
                if (!enable) begin
                    state_d = IDLE;
                    chan_d  = '0;
                    dis_d   = '0;
                end else if (dis_q == DisLast) begin
                    state_d = CHARGE;
                    dis_d   = '0;
                    cnt_d   = '0;
                end else begin
                    dis_d = dis_q + 1'b1;
                end
            end

            CHARGE: begin
                if (!enable) begin
                    state_d = IDLE;
                    chan_d  = '0;
                end else if (pad_high || (cnt_q == MaxCount)) begin
                    state_d       = REPORT;
                    count_out_d   = cnt_q;
                    count_chan_d  = chan_q;
                    timeout_d     = (cnt_q == MaxCount);
                    count_valid_d = 1'b1;
                    if (cnt_q > threshold) begin
                        touched_d[chan_q] = 1'b1;
                    end else if (cnt_q < release_level) begin
                        touched_d[chan_q] = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            REPORT: begin
                chan_d  = (chan_q == ChanLast) ? '0 : chan_q + 1'b1;
                dis_d   = '0;
                state_d = enable ? DISCHARGE : IDLE;
            end

            default: begin
                state_d = IDLE;
                chan_d  = '0;
            end
        endcase

        // Only the pad being timed is ever released; all others stay clamped low.
        sense_oe_d = '1;
        if (state_d == CHARGE) begin
            sense_oe_d[chan_d] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            chan_q        <= '0;
            dis_q         <= '0;
            cnt_q         <= '0;
            sync_meta_q   <= '0;
            sync_q        <= '0;
            sense_oe_q    <= '1;
            touched_q     <= '0;
            count_out_q   <= '0;
            count_chan_q  <= '0;
            count_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            chan_q        <= chan_d;
            dis_q         <= dis_d;
            cnt_q         <= cnt_d;
            sync_meta_q   <= sync_meta_d;
            sync_q        <= sync_d;
            sense_oe_q    <= sense_oe_d;
            touched_q     <= touched_d;
            count_out_q   <= count_out_d;
            count_chan_q  <= count_chan_d;
            count_valid_q <= count_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign sense_oe    = sense_oe_q;
    assign sense_out   = '0;
    assign touched     = touched_q;
    assign count_out   = count_out_q;
    assign count_chan  = count_chan_q;
    assign count_valid = count_valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_capsense_scanner.sv
// Scoreboard bench for capsense_scanner: a pad model releases each pad k cycles after
// its output enable drops; expected reports are queued and checked by a monitor.
module tb_capsense_scanner;

    localparam int NS    = 4;
    localparam int CW    = 8;
    localparam int DC    = 8;
    localparam int CH    = 2;
    localparam int NEVER = 100000;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [CW-1:0] threshold;
    logic [CW-1:0] hysteresis;
    logic [NS-1:0] sense_in;
    logic [NS-1:0] sense_oe;
    logic [NS-1:0] sense_out;
    logic [NS-1:0] touched;
    logic [CW-1:0] count_out;
    logic [CH-1:0] count_chan;
    logic          count_valid;
    logic          timeout;

    capsense_scanner #(
        .NumSense(NS),
        .CountWidth(CW),
        .DischargeCycles(DC),
        .ChanWidth(CH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .threshold(threshold),
        .hysteresis(hysteresis),
        .sense_in(sense_in),
        .sense_oe(sense_oe),
        .sense_out(sense_out),
        .touched(touched),
        .count_out(count_out),
        .count_chan(count_chan),
        .count_valid(count_valid),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Pad model: held low while driven, rises k cycles after the driver lets go.
    int pad_k[NS];
    int pad_cnt[NS];

    always @(posedge clk) begin
        for (int n = 0; n < NS; n++) begin
            pad_cnt[n] <= sense_oe[n] ? 0 : pad_cnt[n] + 1;
        end
    end

    always_comb begin
        sense_in = '0;
        for (int n = 0; n < NS; n++) begin
            sense_in[n] = !sense_oe[n] && (pad_cnt[n] >= pad_k[n]);
        end
    end

    typedef struct {
        int chan;
        int cnt;
        int to;
        int tch;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    logic prev_valid = 1'b0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: pops one expectation per strobe, and watches the pad-drive invariants.
    always @(negedge clk) begin
        exp_t e;
        int   zeros;
        if (!reset) begin
            zeros = 0;
            for (int n = 0; n < NS; n++) begin
                if (!sense_oe[n]) zeros++;
            end
            checkOutput("oe_at_most_one_released", (zeros <= 1) ? 1 : 0, 1);
            if (count_valid && prev_valid) begin
                checkOutput("valid_back_to_back", 1, 0);
            end
            if (count_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_strobe", int'(count_chan), -1);
                end else begin
                    e = sb.pop_front();
                    checkOutput("count_chan", int'(count_chan), e.chan);
                    checkOutput("count_out", int'(count_out), e.cnt);
                    checkOutput("timeout", int'(timeout), e.to);
                    checkOutput("touched_bit", int'(touched[count_chan]), e.tch);
                end
            end
        end
        prev_valid <= count_valid;
    end

    task automatic applyStimulus(input int ch, input int k, input int cnt, input int to,
                                 input int tch);
        exp_t e;
        pad_k[ch] = k;
        e.chan = ch;
        e.cnt  = cnt;
        e.to   = to;
        e.tch  = tch;
        sb.push_back(e);
    endtask

    task automatic waitReport();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!count_valid && n < 400);
        if (!count_valid) checkOutput("report_wait_expired", n, -1);
    endtask

    task automatic waitRelease(input int ch);
        int n;
        n = 0;
        while (sense_oe[ch] && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sense_oe[ch]) checkOutput("release_wait_expired", ch, -1);
    endtask

    task automatic runEntry(input int ch, input int k, input int cnt, input int to,
                            input int tch);
        applyStimulus(ch, k, cnt, to, tch);
        waitReport();
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        enable     = 1'b0;
        threshold  = 8'd40;
        hysteresis = 8'd10;
        for (int i = 0; i < NS; i++) pad_k[i] = NEVER;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_sense_oe", int'(sense_oe), 15);
        checkOutput("rst_sense_out", int'(sense_out), 0);
        checkOutput("rst_touched", int'(touched), 0);
        checkOutput("rst_count_out", int'(count_out), 0);
        checkOutput("rst_count_chan", int'(count_chan), 0);
        checkOutput("rst_count_valid", int'(count_valid), 0);
        checkOutput("rst_timeout", int'(timeout), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("idle_sense_oe", int'(sense_oe), 15);

        // Scan 1; also time the gap from the ch0 report to the ch1 release.
        applyStimulus(0, 20, 22, 0, 0);
        enable = 1'b1;
        waitReport();
        applyStimulus(1, 48, 50, 0, 1);
        n = 0;
        while (sense_oe[1] && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("report_to_next_charge", n, 9);
        waitReport();
        runEntry(2, NEVER, 255, 1, 1);
        runEntry(3, 5, 7, 0, 0);
        // Scan 2
        runEntry(0, 40, 42, 0, 1);
        runEntry(1, 33, 35, 0, 1);
        runEntry(2, 30, 32, 0, 1);
        runEntry(3, 38, 40, 0, 0);
        // Scan 3
        runEntry(0, 26, 28, 0, 0);
        runEntry(1, 26, 28, 0, 0);
        runEntry(2, 26, 28, 0, 0);
        runEntry(3, 0, 2, 0, 0);
        // Scan 4: values on the threshold and release boundaries
        runEntry(0, 39, 41, 0, 1);
        runEntry(1, 28, 30, 0, 0);
        runEntry(2, 29, 31, 0, 0);
        runEntry(3, 28, 30, 0, 0);
        // Scan 5, abandoned during ch3 charge
        runEntry(0, 50, 52, 0, 1);
        runEntry(1, 60, 62, 0, 1);
        runEntry(2, 10, 12, 0, 0);
        pad_k[3] = NEVER;
        waitRelease(3);
        repeat (5) @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("drop_sense_oe", int'(sense_oe), 15);
        checkOutput("drop_count_valid", int'(count_valid), 0);
        checkOutput("drop_touched", int'(touched), 3);
        repeat (20) @(negedge clk);
        checkOutput("drop_touched_held", int'(touched), 3);

        // Re-enable restarts at ch0; then reset lands in the middle of ch1 charge.
        applyStimulus(0, NEVER, 255, 1, 1);
        pad_k[1] = NEVER;
        enable = 1'b1;
        waitReport();
        waitRelease(1);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_sense_oe", int'(sense_oe), 15);
        checkOutput("midrst_touched", int'(touched), 0);
        checkOutput("midrst_count_valid", int'(count_valid), 0);
        checkOutput("midrst_timeout", int'(timeout), 0);
        checkOutput("midrst_count_out", int'(count_out), 0);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checkOutput("postrst_idle_oe", int'(sense_oe), 15);
        end
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
